// File: rtl/dl_pkg.sv
// Shared types and defaults for the download-path memory loader.
package dl_pkg;

  localparam int unsigned ADDR_W_DEF     = 7;
  localparam int unsigned WORDS_DEF      = 128;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  // Place a byte into its big-endian lane: lane 0 is the most significant byte.
  function automatic logic [WORD_W-1:0] insert_lane(
    input logic [WORD_W-1:0] word,
    input logic [LANE_W-1:0] lane,
    input logic [BYTE_W-1:0] data
  );
    logic [WORD_W-1:0] r;
    r = word;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane == LANE_W'(i)) begin
        r[WORD_W-1-(i*BYTE_W) -: BYTE_W] = data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects bytes into a big-endian word; flags the byte that completes a word.
module byte_packer
  import dl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_ready_c
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] cnt;
  logic [WORD_W-1:0] pack;

  // Full word as it will look once the byte on the bus is merged in.
  always_comb begin
    word_c       = insert_lane(pack, cnt, byte_in);
    word_ready_c = accept && (cnt == LAST_LANE);
  end

  // Byte counter and partial-word register; counter wraps after the last lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pack <= '0;
    end else if (clear) begin
      cnt  <= '0;
      pack <= '0;
    end else if (accept) begin
      cnt <= cnt + LANE_W'(1);
      if (cnt == LAST_LANE) begin
        pack <= '0;
      end else begin
        pack <= word_c;
      end
    end
  end

endmodule

// File: rtl/write_addr_gen.sv
// Loads a streamed byte image into word memory, one write per packed word.
module write_addr_gen
  import dl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned WORDS  = WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic [ADDR_W-1:0] write_addr,
  output logic [WORD_W-1:0] write_data,
  output logic              write_en,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_e            state;
  logic              last_wr_c;
  logic              accept_c;
  logic [WORD_W-1:0] word_c;
  logic              word_ready_c;

  // Bytes count only in LOAD; a start cycle and the final write cycle swallow them.
  always_comb begin
    last_wr_c = write_en && (write_addr == LAST_ADDR);
    accept_c  = (state == LOAD) && byte_valid && !start && !last_wr_c;
  end

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (start),
    .accept       (accept_c),
    .byte_in      (byte_in),
    .word_c       (word_c),
    .word_ready_c (word_ready_c)
  );

  // Load FSM, word address counter, write strobe and data holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      write_addr <= '0;
      write_data <= '0;
      write_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      write_en <= 1'b0;
      if (word_ready_c) begin
        write_data <= word_c;
        write_en   <= 1'b1;
      end
      if (start) begin
        state      <= LOAD;
        write_addr <= '0;
        busy       <= 1'b1;
        done       <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (write_en) begin
              if (last_wr_c) begin
                write_addr <= '0;
                state      <= DONE;
                busy       <= 1'b0;
                done       <= 1'b1;
              end else begin
                write_addr <= write_addr + ADDR_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
